// File: rtl/regfile_mp_pkg.sv
// Shared sizing defaults for the multi-port register file and its scoreboard.
package regfile_mp_pkg;

  // Datapath word width and architectural register count
  localparam int WORDSIZE = 32;
  localparam int REG_NUM  = 32;

  // Default port counts for the core register file
  localparam int RF_NREAD  = 2;
  localparam int RF_NWRITE = 1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: one bit per register, set when a producer issues,
// cleared when its result is written back. A fresh issue beats a same-cycle clear.
module regfile_scoreboard #(
  parameter int NREGS    = 32,
  parameter int NWRITE   = 1,
  parameter int NREAD    = 2,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [NWRITE-1:0]    we,
  input  logic [NWRITE*AW-1:0] waddr,
  input  logic                 issueValid,
  input  logic [AW-1:0]        issueAddr,
  input  logic [NREAD*AW-1:0]  raddr,
  output logic [NREAD-1:0]     busyRead
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busyNext;

  // Next busy vector: writebacks clear first, then an issue sets (newest producer wins)
  always_comb begin
    busyNext = busy;
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j]) begin
        busyNext[waddr[j*AW +: AW]] = 1'b0;
      end
    end
    if (issueValid && !(ZERO_REG != 0 && issueAddr == '0)) begin
      busyNext[issueAddr] = 1'b1;
    end
  end

  // Busy register, cleared asynchronously so nothing looks in flight after reset
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busyNext;
    end
  end

  // Per read port lookup; a hardwired zero register is never busy
  always_comb begin
    busyRead = '0;
    for (int i = 0; i < NREAD; i++) begin
      busyRead[i] = busy[raddr[i*AW +: AW]];
      if (ZERO_REG != 0 && raddr[i*AW +: AW] == '0) begin
        busyRead[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: combinational reads, clocked writes with
// highest-port priority, optional hardwired r0, optional write-to-read bypass,
// and a busy scoreboard for hazard detection between issue and writeback.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int  WIDTH    = WORDSIZE,
  parameter int  NREGS    = REG_NUM,
  parameter int  NREAD    = RF_NREAD,
  parameter int  NWRITE   = RF_NWRITE,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic [NREAD*AW-1:0]     raddr,
  output logic [NREAD*WIDTH-1:0]  rdata,
  output logic [NREAD-1:0]        rbusy,
  input  logic [NWRITE-1:0]       we,
  input  logic [NWRITE*AW-1:0]    waddr,
  input  logic [NWRITE*WIDTH-1:0] wdata,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_addr
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREAD-1:0] busyRead;
  logic [AW-1:0]    readAddr;
  logic [WIDTH-1:0] readWord;
  logic             writeHit;
  logic             issueHit;

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .NWRITE  (NWRITE),
    .NREAD   (NREAD),
    .AW      (AW),
    .ZERO_REG(ZERO_REG)
  ) scoreboard (
    .CLK       (CLK),
    .reset     (reset),
    .we        (we),
    .waddr     (waddr),
    .issueValid(issue_valid),
    .issueAddr (issue_addr),
    .raddr     (raddr),
    .busyRead  (busyRead)
  );

  // Storage: ports applied in ascending order so the highest index wins a collision
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && !(ZERO_REG != 0 && waddr[j*AW +: AW] == '0)) begin
          regs[waddr[j*AW +: AW]] <= wdata[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Read ports with bypass forwarding and busy override; everything reads 0 during reset
  always_comb begin
    rdata    = '0;
    rbusy    = '0;
    readAddr = '0;
    readWord = '0;
    writeHit = 1'b0;
    issueHit = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      readAddr = raddr[i*AW +: AW];
      readWord = regs[readAddr];
      writeHit = 1'b0;
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && waddr[j*AW +: AW] == readAddr) begin
          writeHit = 1'b1;
          if (BYPASS != 0) begin
            readWord = wdata[j*WIDTH +: WIDTH];
          end
        end
      end
      issueHit = issue_valid && (issue_addr == readAddr);
      if (ZERO_REG != 0 && readAddr == '0) begin
        readWord = '0;
      end
      rdata[i*WIDTH +: WIDTH] = reset ? '0 : readWord;
      rbusy[i] = !reset && busyRead[i] && !(BYPASS != 0 && writeHit && !issueHit);
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (3 read ports, 2 write ports, r0 hardwired, bypass on).
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int N  = 32;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int AB = 5;

  logic            CLK = 1'b0;
  logic            reset = 1'b1;
  logic [NR*AB-1:0] raddr;
  logic [NR*W-1:0]  rdata;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    we;
  logic [NW*AB-1:0] waddr;
  logic [NW*W-1:0]  wdata;
  logic             issue_valid;
  logic [AB-1:0]    issue_addr;

  logic [AB-1:0] ra [NR];
  logic          weS [NW];
  logic [AB-1:0] wa [NW];
  logic [W-1:0]  wd [NW];
  logic          issV;
  logic [AB-1:0] issA;

  logic [W-1:0]  refReg [N];
  bit            refBusy [N];

  int total = 0;
  int bad = 0;

  regfile_mp #(
    .WIDTH(W), .NREGS(N), .NREAD(NR), .NWRITE(NW), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .raddr      (raddr),
    .rdata      (rdata),
    .rbusy      (rbusy),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr)
  );

  // Free-running clock, 10 time-unit period
  always #5 CLK = ~CLK;

  task applyStimulus();
    for (int i = 0; i < NR; i++) raddr[i*AB +: AB] = ra[i];
    for (int j = 0; j < NW; j++) begin
      we[j]            = weS[j];
      waddr[j*AB +: AB] = wa[j];
      wdata[j*W +: W]  = wd[j];
    end
    issue_valid = issV;
    issue_addr  = issA;
  endtask

  task idleInputs();
    for (int j = 0; j < NW; j++) begin
      weS[j] = 1'b0;
      wa[j]  = '0;
      wd[j]  = '0;
    end
    issV = 1'b0;
    issA = '0;
  endtask

  task clearModel();
    for (int r = 0; r < N; r++) begin
      refReg[r]  = '0;
      refBusy[r] = 1'b0;
    end
  endtask

  task checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task checkBit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Value a reader should see now: stored value, overridden by the last enabled write port to it
  function automatic logic [W-1:0] expData(input logic [AB-1:0] addr);
    logic [W-1:0] v;
    if (reset || addr == 0) return '0;
    v = refReg[addr];
    for (int j = 0; j < NW; j++) if (weS[j] && wa[j] == addr) v = wd[j];
    return v;
  endfunction

  // Busy as a reader sees it: pending producer, unless its result is being written right now
  function automatic logic expBusy(input logic [AB-1:0] addr);
    bit written;
    if (reset || addr == 0) return 1'b0;
    written = 1'b0;
    for (int j = 0; j < NW; j++) if (weS[j] && wa[j] == addr) written = 1'b1;
    if (written && !(issV && issA == addr)) return 1'b0;
    return refBusy[addr];
  endfunction

  task updateModel();
    for (int j = 0; j < NW; j++) if (weS[j] && wa[j] != 0) refReg[wa[j]] = wd[j];
    for (int j = 0; j < NW; j++) if (weS[j]) refBusy[wa[j]] = 1'b0;
    if (issV && issA != 0) refBusy[issA] = 1'b1;
  endtask

  task checkOutput(input string tag);
    for (int i = 0; i < NR; i++) begin
      checkVal($sformatf("%s rdata%0d", tag, i), rdata[i*W +: W], expData(ra[i]));
      checkBit($sformatf("%s rbusy%0d", tag, i), rbusy[i], expBusy(ra[i]));
    end
  endtask

  // Drive at a falling edge, then let outputs settle
  task drive();
    applyStimulus();
    #1;
  endtask

  // Take the rising edge into the model, return at the next falling edge
  task finishCycle();
    @(posedge CLK);
    if (!reset) updateModel();
    @(negedge CLK);
  endtask

  initial begin
    idleInputs();
    ra[0] = 5'd5; ra[1] = 5'd9; ra[2] = 5'd3;
    clearModel();
    drive();
    checkVal("reset rdata0", rdata[0 +: W], 32'h0);
    checkBit("reset rbusy1", rbusy[1], 1'b0);
    #2 reset = 1'b0;
    @(negedge CLK);

    // Test 1: write r5, issue r9, then an asynchronous reset pulse between edges
    weS[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
    issV = 1'b1; issA = 5'd9;
    ra[0] = 5'd5; ra[1] = 5'd9; ra[2] = 5'd0;
    drive();
    checkOutput("t1 write");
    finishCycle();
    idleInputs();
    drive();
    checkVal("t1 r5 stored", rdata[0 +: W], 32'hDEADBEEF);
    checkBit("t1 r9 busy", rbusy[1], 1'b1);
    reset = 1'b1;
    #1;
    checkVal("t1 r5 after reset", rdata[0 +: W], 32'h0);
    for (int a = 0; a < N; a++) begin
      ra[0] = a[AB-1:0];
      applyStimulus();
      #1;
      checkBit($sformatf("t1 rbusy addr%0d", a), rbusy[0], 1'b0);
    end
    clearModel();
    @(negedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    ra[0] = 5'd5; ra[1] = 5'd9;
    drive();
    checkVal("t1 r5 post reset", rdata[0 +: W], 32'h0);
    checkOutput("t1 post");
    finishCycle();

    // Test 2: basic write with same-cycle bypass
    weS[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h12345678;
    ra[0] = 5'd3;
    drive();
    checkVal("t2 bypass", rdata[0 +: W], 32'h12345678);
    finishCycle();
    idleInputs();
    drive();
    checkVal("t2 stored", rdata[0 +: W], 32'h12345678);
    finishCycle();

    // Test 3: r0 ignores writes and issues
    weS[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF;
    issV = 1'b1; issA = 5'd0;
    ra[0] = 5'd0; ra[1] = 5'd0; ra[2] = 5'd0;
    drive();
    for (int i = 0; i < NR; i++) begin
      checkVal($sformatf("t3 r0 bypass%0d", i), rdata[i*W +: W], 32'h0);
      checkBit($sformatf("t3 r0 busy now%0d", i), rbusy[i], 1'b0);
    end
    finishCycle();
    idleInputs();
    drive();
    for (int i = 0; i < NR; i++) begin
      checkVal($sformatf("t3 r0 read%0d", i), rdata[i*W +: W], 32'h0);
      checkBit($sformatf("t3 r0 busy%0d", i), rbusy[i], 1'b0);
    end
    finishCycle();

    // Test 4: both write ports target r7, port 1 wins
    weS[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'h1;
    weS[1] = 1'b1; wa[1] = 5'd7; wd[1] = 32'h2;
    ra[0] = 5'd7;
    drive();
    checkVal("t4 bypass conflict", rdata[0 +: W], 32'h2);
    finishCycle();
    idleInputs();
    drive();
    checkVal("t4 stored conflict", rdata[0 +: W], 32'h2);
    finishCycle();

    // Test 5: scoreboard issue / writeback / same-cycle issue+write on r9
    issV = 1'b1; issA = 5'd9; ra[0] = 5'd9;
    drive();
    checkBit("t5 not yet busy", rbusy[0], 1'b0);
    finishCycle();
    idleInputs();
    drive();
    checkBit("t5 busy after issue", rbusy[0], 1'b1);
    finishCycle();
    weS[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'hAAAA5555;
    drive();
    checkBit("t5 busy hidden by write", rbusy[0], 1'b0);
    checkVal("t5 write bypass", rdata[0 +: W], 32'hAAAA5555);
    finishCycle();
    idleInputs();
    drive();
    checkBit("t5 busy cleared", rbusy[0], 1'b0);
    finishCycle();
    issV = 1'b1; issA = 5'd9;
    drive();
    finishCycle();
    weS[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h0BADF00D;
    issV = 1'b1; issA = 5'd9;
    drive();
    checkBit("t5 issue+write same cycle", rbusy[0], 1'b1);
    finishCycle();
    idleInputs();
    drive();
    checkBit("t5 busy kept", rbusy[0], 1'b1);
    checkVal("t5 data written", rdata[0 +: W], 32'h0BADF00D);
    finishCycle();

    // Test 6: random traffic against the reference model, with reset pulses
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NR; i++)
        ra[i] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      for (int j = 0; j < NW; j++) begin
        weS[j] = ($urandom_range(0, 2) != 0);
        wa[j]  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wd[j]  = $urandom;
      end
      issV = ($urandom_range(0, 1) != 0);
      issA = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        drive();
        checkOutput($sformatf("rand%0d in reset", c));
        @(posedge CLK);
        clearModel();
        #2 reset = 1'b0;
        @(negedge CLK);
      end else begin
        drive();
        checkOutput($sformatf("rand%0d", c));
        finishCycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
